// File: rtl/div_job_controller.sv
// rtl/div_job_controller.sv - job sequencer in front of general_divider
module div_job_controller #(
   parameter int WIDTH_A   = 4,
   parameter int WIDTH_B   = 4,
   parameter int TMO_SLACK = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH_A-1:0] in_a,
   input  logic [WIDTH_B-1:0] in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH_A-1:0] out_q,
   output logic [WIDTH_B-1:0] out_r,
   output logic               out_dbz,
   output logic               out_timeout,
   output logic               busy,
   output logic               div_reset,
   output logic [WIDTH_A-1:0] div_a,
   output logic [WIDTH_B-1:0] div_b,
   input  logic [WIDTH_A-1:0] div_q,
   input  logic [WIDTH_B-1:0] div_r,
   input  logic               div_done
);

   localparam int TMO  = WIDTH_A + TMO_SLACK;
   localparam int WD_W = $clog2(TMO + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TMO - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, OUT} state_t;

   state_t          state;
   logic [WD_W-1:0] wd;

   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign out_valid = (state == OUT);
   // The divider is also held in reset whenever the controller is.
   assign div_reset = reset | (state == LOAD);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         wd          <= '0;
         out_q       <= '0;
         out_r       <= '0;
         out_dbz     <= 1'b0;
         out_timeout <= 1'b0;
         div_a       <= '0;
         div_b       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  if (in_b != '0) begin
                     div_a <= in_a;
                     div_b <= in_b;
                     state <= LOAD;
                  end else begin
                     out_q       <= '1;
                     out_r       <= '0;
                     out_dbz     <= 1'b1;
                     out_timeout <= 1'b0;
                     state       <= OUT;
                  end
               end
            end
            LOAD: begin
               wd    <= '0;
               state <= RUN;
            end
            // div_done is only trusted here; in LOAD it may still be left over from the last job.
            RUN: begin
               if (div_done) begin
                  out_q       <= div_q;
                  out_r       <= div_r;
                  out_dbz     <= 1'b0;
                  out_timeout <= 1'b0;
                  state       <= OUT;
               end else if (wd == WD_LAST) begin
                  out_q       <= '0;
                  out_r       <= '0;
                  out_dbz     <= 1'b0;
                  out_timeout <= 1'b1;
                  state       <= OUT;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            OUT: begin
               if (out_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_job_controller.sv
// tb/tb_div_job_controller.sv - directed bench for div_job_controller with a behavioural divider
module tb_div_job_controller;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid, in_ready;
   logic [W-1:0] in_a, in_b;
   logic         out_valid, out_ready;
   logic [W-1:0] out_q, out_r;
   logic         out_dbz, out_timeout, busy, div_reset;
   logic [W-1:0] div_a, div_b, div_q, div_r;
   logic         div_done;

   int errors = 0;
   int checks = 0;

   div_job_controller #(.WIDTH_A(W), .WIDTH_B(W), .TMO_SLACK(2)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_r(out_r),
      .out_dbz(out_dbz), .out_timeout(out_timeout), .busy(busy),
      .div_reset(div_reset), .div_a(div_a), .div_b(div_b),
      .div_q(div_q), .div_r(div_r), .div_done(div_done)
   );

   always #5 clk = ~clk;

   // Divider model: done rises W+1 edges after reset release and stays high (stale) until next reset.
   logic [3:0] dcnt;
   logic       stuck;
   int         load_pulses = 0;
   always @(posedge clk) begin
      if (div_reset) begin
         dcnt     <= '0;
         div_done <= 1'b0;
         div_q    <= (div_b != 0) ? div_a / div_b : '0;
         div_r    <= (div_b != 0) ? div_a % div_b : '0;
      end else if (!stuck) begin
         if (dcnt < 4'(W)) dcnt <= dcnt + 1'b1;
         div_done <= (dcnt == 4'(W));
      end
      if (div_reset && !reset) load_pulses <= load_pulses + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
   endtask

   task automatic do_job(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input logic eto, input int elat, input int hold);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check("in_ready before job", in_ready, 1);
      in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      wait_out(n);
      check("latency", n, elat);
      check("out_valid", out_valid, 1);
      check("out_q", out_q, eq);
      check("out_r", out_r, er);
      check("out_dbz", out_dbz, edbz);
      check("out_timeout", out_timeout, eto);
      for (int i = 0; i < hold; i++) begin
         tick();
         check("hold valid", out_valid, 1);
         check("hold q", out_q, eq);
         check("hold r", out_r, er);
         check("hold in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("valid drops after handshake", out_valid, 0);
      check("idle after handshake", in_ready, 1);
   endtask

   initial begin
      int n, p0;
      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0; stuck = 1'b0;
      tick();
      tick();
      check("rst div_reset", div_reset, 1);
      check("rst out_valid", out_valid, 0);
      check("rst out_q", out_q, 0);
      check("rst out_r", out_r, 0);
      check("rst div_a", div_a, 0);
      check("rst div_b", div_b, 0);
      check("rst in_ready", in_ready, 1);
      check("rst busy", busy, 0);
      reset = 1'b0;
      tick();
      check("div_reset idle", div_reset, 0);

      do_job(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0, 7, 0);

      p0 = load_pulses;
      do_job(4'd9, 4'd0, 4'hF, 4'd0, 1'b1, 1'b0, 0, 0);
      check("dbz no divider pulse", load_pulses - p0, 0);

      do_job(4'd15, 4'd15, 4'd1, 4'd0, 1'b0, 1'b0, 7, 10);

      // back-to-back with in_valid held high
      in_a = 4'd7; in_b = 4'd2; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_a = 4'd8; in_b = 4'd3;
      check("b2b operand a stable", div_a, 7);
      wait_out(n);
      check("b2b1 q", out_q, 3);
      check("b2b1 r", out_r, 1);
      tick();
      wait_out(n);
      in_valid = 1'b0;
      check("b2b2 q", out_q, 2);
      check("b2b2 r", out_r, 2);
      tick();
      out_ready = 1'b0;
      check("b2b idle", in_ready, 1);

      stuck = 1'b1;
      do_job(4'd13, 4'd3, 4'd0, 4'd0, 1'b0, 1'b1, 7, 0);
      stuck = 1'b0;
      do_job(4'd13, 4'd3, 4'd4, 4'd1, 1'b0, 1'b0, 7, 0);

      // reset two cycles into RUN
      in_a = 4'd11; in_b = 4'd2; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      check("busy in RUN", busy, 1);
      reset = 1'b1;
      #1;
      check("div_reset during reset", div_reset, 1);
      tick();
      reset = 1'b0;
      check("post reset out_valid", out_valid, 0);
      check("post reset in_ready", in_ready, 1);
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (out_valid) n++;
      end
      check("no stale result", n, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
